// File: rtl/collatz_pkg.sv
// Shared FSM encoding, control-byte layout and length width for the Collatz sweep host.
package collatz_pkg;

  localparam int LEN_W   = 16;
  localparam int ADDR_W  = 5;
  localparam int CTL_WE  = 7;
  localparam int CTL_GO  = 6;
  localparam int CTL_REC = 5;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLR,
    S_LOAD,
    S_GO,
    S_ARM,
    S_WAIT,
    S_RSET,
    S_RCAP,
    S_UPD,
    S_FIN
  } state_t;

  // Packs {we, go, rec, addr[4:0]} into the core's control byte.
  function automatic logic [7:0] ctl_byte(input logic we, input logic go, input logic rec,
                                          input logic [ADDR_W-1:0] addr);
    logic [7:0] b;
    b               = 8'h00;
    b[CTL_WE]       = we;
    b[CTL_GO]       = go;
    b[CTL_REC]      = rec;
    b[ADDR_W-1:0]   = addr;
    return b;
  endfunction

endpackage

// File: rtl/collatz_sweeper.sv
// Sweeps a seed range through an external byte-bus Collatz core and keeps the longest orbit.
// Optional COLLATZ_SWEEP_PATH_EN adds best_path and two extra path-record reads per seed.
module collatz_sweeper
  import collatz_pkg::*;
#(
  parameter int SEED_W     = 32,
  parameter int LOAD_BYTES = 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [SEED_W-1:0] seed_first,
  input  logic [SEED_W-1:0] seed_last,
  output logic              running,
  output logic              done,
  output logic [SEED_W-1:0] best_seed,
  output logic [LEN_W-1:0]  best_len,
`ifdef COLLATZ_SWEEP_PATH_EN
  output logic [15:0]       best_path,
`endif
  output logic              core_rst_n,
  output logic [7:0]        core_ui,
  output logic [7:0]        core_uio,
  input  logic [7:0]        core_uo,
  input  logic              core_busy
);

`ifdef COLLATZ_SWEEP_PATH_EN
  localparam int NUM_RD = 4;
`else
  localparam int NUM_RD = 2;
`endif
  // Zero-padded copy of cur so any load index selects a byte in range.
  localparam int PAD_W = 256;

  state_t            state, state_nx;
  logic [SEED_W-1:0] cur, last;
  logic [ADDR_W-1:0] ld_idx;
  logic [1:0]        rd_idx;
  logic [LEN_W-1:0]  rd_len;
`ifdef COLLATZ_SWEEP_PATH_EN
  logic [15:0]       rd_path;
`endif
  logic              rst_q;
  logic [PAD_W-1:0]  cur_pad;
  logic              last_ld, last_rd;

  assign cur_pad = PAD_W'(cur);
  assign last_ld = (ld_idx == ADDR_W'(LOAD_BYTES - 1));
  assign last_rd = (rd_idx == 2'(NUM_RD - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (start) state_nx = (seed_first > seed_last) ? S_FIN : S_CLR;
      S_CLR:   state_nx = S_LOAD;
      S_LOAD:  if (last_ld) state_nx = S_GO;
      S_GO:    state_nx = S_ARM;
      S_ARM:   state_nx = S_WAIT;
      S_WAIT:  if (!core_busy) state_nx = S_RSET;
      S_RSET:  state_nx = S_RCAP;
      S_RCAP:  state_nx = last_rd ? S_UPD : S_RSET;
      S_UPD:   state_nx = (cur == last) ? S_FIN : S_CLR;
      S_FIN:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Core bus decode; read index i maps to rec=i[1], addr=i[0].
  always_comb begin
    core_ui  = 8'h00;
    core_uio = 8'h00;
    case (state)
      S_LOAD: begin
        core_ui  = cur_pad[{ld_idx, 3'b000} +: 8];
        core_uio = ctl_byte(1'b1, 1'b0, 1'b0, ld_idx);
      end
      S_GO:           core_uio = ctl_byte(1'b0, 1'b1, 1'b0, 5'd0);
      S_RSET, S_RCAP: core_uio = ctl_byte(1'b0, 1'b0, rd_idx[1], {4'b0000, rd_idx[0]});
      default: ;
    endcase
  end

  assign running = (state != S_IDLE);
  assign done    = (state == S_FIN);

  // rst_q holds the core in reset for the cycles reset is seen, releasing one cycle after.
  always_ff @(posedge clk) rst_q <= reset;
  assign core_rst_n = !rst_q && (state != S_CLR);

  always_ff @(posedge clk) begin
    if (reset) begin
      cur       <= '0;
      last      <= '0;
      best_seed <= '0;
      best_len  <= '0;
      ld_idx    <= '0;
      rd_idx    <= '0;
      rd_len    <= '0;
`ifdef COLLATZ_SWEEP_PATH_EN
      rd_path   <= '0;
      best_path <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: if (start) begin
          cur       <= seed_first;
          last      <= seed_last;
          best_seed <= '0;
          best_len  <= '0;
`ifdef COLLATZ_SWEEP_PATH_EN
          best_path <= '0;
`endif
        end
        S_CLR:  ld_idx <= '0;
        S_LOAD: ld_idx <= ld_idx + 1'b1;
        S_WAIT: rd_idx <= '0;
        S_RCAP: begin
          case (rd_idx)
            2'd0: rd_len[7:0]   <= core_uo;
            2'd1: rd_len[15:8]  <= core_uo;
`ifdef COLLATZ_SWEEP_PATH_EN
            2'd2: rd_path[7:0]  <= core_uo;
            2'd3: rd_path[15:8] <= core_uo;
`endif
            default: ;
          endcase
          rd_idx <= rd_idx + 1'b1;
        end
        S_UPD: begin
          // Strict compare so ties keep the earlier seed.
          if (rd_len > best_len) begin
            best_seed <= cur;
            best_len  <= rd_len;
`ifdef COLLATZ_SWEEP_PATH_EN
            best_path <= rd_path;
`endif
          end
          // No increment on the final seed, so an all-ones last seed cannot wrap.
          if (cur != last) cur <= cur + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_collatz_sweeper.sv
// Directed bench for collatz_sweeper with a behavioural byte-bus Collatz core.
`timescale 1ns/1ps
module tb_collatz_sweeper;

  localparam int SEED_W     = 32;
  localparam int LOAD_BYTES = 18;

  logic              clk = 1'b0;
  logic              reset, start;
  logic [SEED_W-1:0] seed_first, seed_last;
  logic              running, done;
  logic [SEED_W-1:0] best_seed;
  logic [15:0]       best_len;
`ifdef COLLATZ_SWEEP_PATH_EN
  logic [15:0]       best_path;
`endif
  logic              core_rst_n;
  logic [7:0]        core_ui, core_uio, core_uo;
  logic              core_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  collatz_sweeper #(.SEED_W(SEED_W), .LOAD_BYTES(LOAD_BYTES)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .seed_first (seed_first),
    .seed_last  (seed_last),
    .running    (running),
    .done       (done),
    .best_seed  (best_seed),
    .best_len   (best_len),
`ifdef COLLATZ_SWEEP_PATH_EN
    .best_path  (best_path),
`endif
    .core_rst_n (core_rst_n),
    .core_ui    (core_ui),
    .core_uio   (core_uio),
    .core_uo    (core_uo),
    .core_busy  (core_busy)
  );

  // Core model: 18 seed bytes, one step per cycle from the go edge, length counts steps to 1.
  function automatic logic [143:0] cstep(input logic [143:0] n);
    return n[0] ? (n * 3 + 1) : (n >> 1);
  endfunction

  function automatic int ref_len(input logic [143:0] s);
    logic [143:0] n;
    int len;
    n   = s;
    len = 0;
    do begin
      n = cstep(n);
      len++;
    end while (n != 1 && len < 60000);
    return len;
  endfunction

  logic [143:0] m_seed, m_n;
  logic [15:0]  m_len;
  logic         m_busy;
  logic [7:0]   m_uo;

  always @(posedge clk) begin
    if (!core_rst_n) begin
      m_seed <= '0;
      m_n    <= '0;
      m_len  <= '0;
      m_busy <= 1'b0;
      m_uo   <= 8'h00;
    end else begin
      if (core_uio[7] && core_uio[4:0] < 5'd18)
        m_seed[{core_uio[4:0], 3'b000} +: 8] <= core_ui;
      if (core_uio[6]) begin
        m_n    <= cstep(m_seed);
        m_len  <= 16'd1;
        m_busy <= (cstep(m_seed) != 1);
      end else if (m_busy) begin
        m_n    <= cstep(m_n);
        m_len  <= m_len + 16'd1;
        m_busy <= (cstep(m_n) != 1);
      end
      case ({core_uio[5], core_uio[0]})
        2'b00:   m_uo <= m_len[7:0];
        2'b01:   m_uo <= m_len[15:8];
        default: m_uo <= 8'h00;
      endcase
    end
  end

  assign core_uo   = m_uo;
  assign core_busy = m_busy;

  // Event counters sampled at the active edge.
  int         done_cnt = 0, clr_cnt = 0, run_cyc = 0, wr_n = 0, uio_bad = 0;
  logic [4:0] wr_addr [256];
  logic [7:0] wr_data [256];

  always @(posedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (!reset && !core_rst_n) clr_cnt <= clr_cnt + 1;
    if (running) run_cyc <= run_cyc + 1;
    if (core_uio[7]) begin
      wr_addr[wr_n % 256] <= core_uio[4:0];
      wr_data[wr_n % 256] <= core_ui;
      wr_n <= wr_n + 1;
    end
    if (core_busy && core_uio != 8'h00) uio_bad <= uio_bad + 1;
  end

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic kick(input logic [SEED_W-1:0] f, input logic [SEED_W-1:0] l);
    seed_first = f;
    seed_last  = l;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  int d0, c0, r0, w0, len_ff;
  bit ok;

  initial begin
    reset = 1'b1; start = 1'b0; seed_first = '0; seed_last = '0;
    repeat (3) @(negedge clk);
    check("rst_running", running, 0);
    check("rst_done", done, 0);
    check("rst_best_seed", best_seed, 0);
    check("rst_best_len", best_len, 0);
    check("rst_uio", core_uio, 0);
    check("rst_ui", core_ui, 0);
    check("rst_core_rst_n", core_rst_n, 0);
    reset = 1'b0;
    @(negedge clk);
    check("rel_core_rst_n", core_rst_n, 1);
    check("rel_running", running, 0);

    // Seeds 1..3: lengths 3,1,7; runs 28+27+32 cycles.
    d0 = done_cnt; c0 = clr_cnt; r0 = run_cyc;
    kick(1, 3);
    wait_done(2000, ok);
    check("s13_done_seen", ok, 1);
    check("s13_best_seed", best_seed, 3);
    check("s13_best_len", best_len, 7);
    check("s13_cycles", run_cyc - r0, 87);
    @(negedge clk);
    check("s13_done_low", done, 0);
    check("s13_idle", running, 0);
    check("s13_done_cnt", done_cnt - d0, 1);
    check("s13_clr_cnt", clr_cnt - c0, 3);
    check("idle_uio", core_uio, 0);
    check("idle_ui", core_ui, 0);

    // Seed 27 with a stray start during LOAD; write stream must be 27,0,0,...
    d0 = done_cnt; c0 = clr_cnt; r0 = run_cyc; w0 = wr_n;
    kick(27, 27);
    repeat (4) @(negedge clk);
    kick(5, 9);
    wait_done(2000, ok);
    check("s27_done_seen", ok, 1);
    check("s27_best_seed", best_seed, 27);
    check("s27_best_len", best_len, 111);
    check("s27_cycles", run_cyc - r0, 136);
    check("s27_wr_cnt", wr_n - w0, LOAD_BYTES);
    for (int k = 0; k < LOAD_BYTES; k++) begin
      check($sformatf("s27_wr_addr%0d", k), wr_addr[(w0 + k) % 256], k);
      check($sformatf("s27_wr_data%0d", k), wr_data[(w0 + k) % 256], (k == 0) ? 27 : 0);
    end
`ifdef COLLATZ_SWEEP_PATH_EN
    check("s27_best_path", best_path, 0);
`endif
    @(negedge clk);
    check("s27_done_cnt", done_cnt - d0, 1);
    check("s27_clr_cnt", clr_cnt - c0, 1);

    // Reversed range: start in cycle 1, done in cycle 2, nothing run, best cleared.
    d0 = done_cnt; c0 = clr_cnt;
    kick(5, 4);
    check("rev_done", done, 1);
    check("rev_running", running, 1);
    check("rev_best_seed", best_seed, 0);
    check("rev_best_len", best_len, 0);
    @(negedge clk);
    check("rev_done_low", done, 0);
    check("rev_idle", running, 0);
    check("rev_clr_cnt", clr_cnt - c0, 0);
    check("rev_done_cnt", done_cnt - d0, 1);

    // All-ones seed: exactly one run, no wrap back to 0.
    len_ff = ref_len(144'hFFFF_FFFF);
    d0 = done_cnt; c0 = clr_cnt; r0 = run_cyc;
    kick(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(20000, ok);
    check("max_done_seen", ok, 1);
    check("max_best_seed", best_seed, 32'hFFFF_FFFF);
    check("max_best_len", best_len, len_ff);
    check("max_cycles", run_cyc - r0, len_ff + 25);
    @(negedge clk);
    check("max_done_cnt", done_cnt - d0, 1);
    check("max_clr_cnt", clr_cnt - c0, 1);
    check("max_idle", running, 0);

    // Reset while the core is busy abandons the sweep silently.
    d0 = done_cnt;
    kick(27, 27);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (core_busy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("rw_busy_seen", ok, 1);
    repeat (10) @(negedge clk);
    check("wait_uio", core_uio, 0);
    check("wait_ui", core_ui, 0);
    reset = 1'b1;
    @(negedge clk);
    check("rw_uio", core_uio, 0);
    check("rw_core_rst_n", core_rst_n, 0);
    check("rw_running", running, 0);
    check("rw_best_len", best_len, 0);
    reset = 1'b0;
    @(negedge clk);
    check("rw_rel_core_rst_n", core_rst_n, 1);
    repeat (200) @(negedge clk);
    check("rw_no_done", done_cnt - d0, 0);
    check("rw_idle", running, 0);

    // Fresh sweep after reset; seed 2 has busy already low in ARM.
    d0 = done_cnt; r0 = run_cyc;
    kick(2, 2);
    wait_done(2000, ok);
    check("s2_done_seen", ok, 1);
    check("s2_best_seed", best_seed, 2);
    check("s2_best_len", best_len, 1);
    check("s2_cycles", run_cyc - r0, 27);
    @(negedge clk);
    check("s2_done_cnt", done_cnt - d0, 1);

    check("uio_quiet_while_busy", uio_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
